seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an NDIG-digit common-segment 7-seg display.
//  Holds a frame of packed BCD digits and steps one shared BCD-to-7seg decoder across them.
//  Drives the decoder input (bcd), a one-hot digit enable (an) and a blank flag.
//  New frames load via valid/ready and commit only at a frame boundary (no tearing).
// PARAMETERS
//  NDIG      4    number of digits scanned (>=2)
//  PRESCALE  1000 clk cycles each digit is lit (>=1)
//  DEAD      2    clk cycles all digits are off between digits (anti-ghosting, >=0)
//  LZB       1    1 = blank leading zeros (the least significant digit is never blanked)
// PORTS
//  clk         in   1        system clock, all logic on rising edge
//  rst         in   1        synchronous reset, active-high
//  enable      in   1        1 = scan; 0 = display off
//  load_valid  in   1        new frame offered on load_data
//  load_data   in   4*NDIG   digit k at [4k+3:4k]; digit 0 = least significant
//  load_ready  out  1        controller can accept a frame
//  bcd         out  4        digit value presented to the shared decoder
//  an          out  NDIG     one-hot digit enable, active-high; all-zero = off
//  blank       out  1        1 = downstream forces all segments off
//  frame_done  out  1        one-cycle pulse after the last digit's dead time
// BEHAVIOUR
//  Clock and reset: one clock (clk); rst is synchronous, active-high.
//  Reset values: an=0, bcd=0, blank=1, frame_done=0, load_ready=1, idx=0, state=OFF.
//  Reset also clears the active frame and pending frame to 0. A reset asserted
//   mid-scan or mid-handshake wins over all other inputs in that cycle.
//  Registers: active[4*NDIG], pending[4*NDIG], pend flag, idx (digit index),
//   cnt (prescale/dead counter). All outputs are registered.
//  FSM states:
//   OFF: an=0, blank=1. If enable=1, go to LIT with idx=0, cnt=0.
//   LIT: an=onehot(idx), bcd=active[idx]. cnt counts 0..PRESCALE-1, then:
//    DEAD>0  -> GAP, cnt=0.
//    DEAD==0 -> advance directly as described for GAP exit.
//   GAP: an=0, blank=1, held for DEAD cycles. On exit:
//    idx<NDIG-1 -> idx+1, go to LIT.
//    idx==NDIG-1 -> frame boundary: pulse frame_done, idx=0, go to LIT.
//  enable=0 in any state: next cycle go to OFF, an=0, idx=0, cnt=0. There is no partial-frame pulse.
//  Digit period: PRESCALE+DEAD cycles. Frame period: NDIG*(PRESCALE+DEAD) cycles.
//  Blank rules in LIT (blank=1 means bcd is driven 0):
//   - digit value >9 (invalid BCD) -> blank=1, bcd=0; an is still asserted.
//   - LZB=1 and all digits from idx up to NDIG-1 are 0 and idx!=0 -> blank=1.
//   - otherwise blank=0.
//  Load handshake:
//   - load_ready = ~pend.
//   - A transfer occurs when load_valid and load_ready are both 1. It captures
//     load_data into pending, sets pend, and drops load_ready the next cycle.
//   - Commit: at a frame boundary (same cycle frame_done is asserted), or on the
//     first cycle in OFF, pending is copied to active and pend is cleared.
//     load_ready rises the cycle after the commit.
//   - The first digit of the next frame shows the new data.
//   - load_valid while load_ready=0 is ignored. load_data need not be held once
//     the transfer has occurred.
//  Wrap-around: idx wraps NDIG-1 -> 0. cnt is sized $clog2(max(PRESCALE,DEAD,2)).
// TESTING  (NDIG=4, PRESCALE=4, DEAD=1, LZB=1 unless noted)
//  1 Reset mid-scan: assert rst during LIT idx=2 -> next cycle an=0, blank=1, load_ready=1.
//    After release with enable=1, scanning restarts at an=0001.
//  2 Scan order: active=16'h4321, enable=1 -> an 0001,0000,0010,0000,0100,0000,1000,0000.
//    Each lit digit holds 4 cycles, each gap 1 cycle; bcd=1,2,3,4;
//    frame_done pulses every 20 cycles.
//  3 Tear-free load: load 16'h9876 at idx=1 -> load_ready=0 until the boundary.
//    The current frame still shows 1,2,3,4; the next frame shows 6,7,8,9.
//  4 Leading-zero and invalid: load 16'h00A0 -> idx3,idx2 blank=1;
//    idx1 (value A) blank=1, bcd=0; idx0 shows bcd=0, blank=0.
//  5 Enable toggle and OFF load: drop enable mid-frame -> an=0 next cycle, no frame_done.
//    Load 16'h5555 while OFF -> commits in 1 cycle and load_ready returns to 1.
//    Re-enable -> the first lit digit is idx0, bcd=5.
//  6 DEAD=0, PRESCALE=1: an rotates every cycle 0001->0010->0100->1000->0001.
//    frame_done pulses every 4 cycles.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Scan controller for an NDIG-digit, time-multiplexed 7-segment display.
//   It holds one frame of packed BCD digits and walks a single shared
//   BCD-to-7seg decoder across them. Each digit is lit for PRESCALE cycles,
//   followed by DEAD cycles with every digit off. A new frame is accepted
//   through a valid/ready port. It only replaces the displayed frame at a
//   frame boundary, or while the display is off, so a frame never tears.
//
//   Handshake: a transfer happens on a rising clk edge where load_valid and
//   load_ready are both 1. load_ready depends only on internal state, never
//   on load_valid. load_data is captured on that edge and need not be held
//   afterwards.
//
// Ports
//   clk         in   1       system clock, rising edge
//   rst         in   1       synchronous reset, active-high
//   enable      in   1       1 = scan, 0 = display off
//   load_valid  in   1       frame offered on load_data
//   load_data   in   4*NDIG  digit k at [4k+3:4k], digit 0 least significant
//   load_ready  out  1       a frame can be accepted (no frame pending)
//   bcd         out  4       value presented to the shared decoder
//   an          out  NDIG    one-hot digit enable, all-zero = off
//   blank       out  1       1 = force all segments off
//   frame_done  out  1       one-cycle pulse at the start of each new frame
module seg_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 1000,
  parameter int DEAD     = 2,
  parameter int LZB      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load_valid,
  input  logic [4*NDIG-1:0] load_data,
  output logic              load_ready,
  output logic [3:0]        bcd,
  output logic [NDIG-1:0]   an,
  output logic              blank,
  output logic              frame_done
);

  localparam int MX = (PRESCALE > DEAD) ? PRESCALE : DEAD;
  localparam int CW = $clog2((MX > 2) ? MX : 2);
  localparam int IW = $clog2(NDIG);

  localparam logic [CW-1:0] PRE_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] DEAD_LAST = (DEAD > 0) ? CW'(DEAD - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_LIT = 2'd1,
    S_GAP = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [IW-1:0]     idx, idx_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [4*NDIG-1:0] active, active_n;
  logic [4*NDIG-1:0] pending, pending_n;
  logic              pend, pend_n;

  logic              step;      // current digit finished, move to the next
  logic              boundary;  // last digit finished, new frame starts
  logic [3:0]        digit;
  logic              upper_nz;  // some digit at or above idx is nonzero
  logic [NDIG-1:0]   an_n;
  logic [3:0]        bcd_n;
  logic              blank_n;

  // Next-state: sequencing, handshake and commit
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    active_n  = active;
    pending_n = pending;
    pend_n    = pend;
    step      = 1'b0;
    boundary  = 1'b0;

    if (!enable) begin
      state_n = S_OFF;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        S_OFF: begin
          state_n = S_LIT;
          idx_n   = '0;
          cnt_n   = '0;
        end
        S_LIT: begin
          if (cnt == PRE_LAST) begin
            cnt_n = '0;
            if (DEAD > 0) state_n = S_GAP;
            else          step    = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == DEAD_LAST) begin
            cnt_n = '0;
            step  = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = S_OFF;
          idx_n   = '0;
          cnt_n   = '0;
        end
      endcase

      if (step) begin
        state_n = S_LIT;
        if (idx == IDX_LAST) begin
          idx_n    = '0;
          boundary = 1'b1;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
    end

    // Commit and transfer need opposite values of pend, so at most one fires.
    if (pend && (boundary || state == S_OFF)) begin
      active_n = pending;
      pend_n   = 1'b0;
    end else if (load_valid && !pend) begin
      pending_n = load_data;
      pend_n    = 1'b1;
    end
  end

  // Output decode from next-state values so registered outputs line up with
  // the state they describe, and a freshly committed frame shows at once.
  always_comb begin
    digit    = 4'd0;
    upper_nz = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (k == int'(idx_n)) digit = active_n[4*k +: 4];
      if (k >= int'(idx_n) && active_n[4*k +: 4] != 4'd0) upper_nz = 1'b1;
    end

    an_n    = '0;
    bcd_n   = 4'd0;
    blank_n = 1'b1;
    if (state_n == S_LIT) begin
      an_n = NDIG'(1) << idx_n;
      if (digit > 4'd9) begin
        blank_n = 1'b1;
      end else if (LZB != 0 && idx_n != '0 && !upper_nz) begin
        blank_n = 1'b1;
      end else begin
        blank_n = 1'b0;
        bcd_n   = digit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_OFF;
      idx        <= '0;
      cnt        <= '0;
      active     <= '0;
      pending    <= '0;
      pend       <= 1'b0;
      an         <= '0;
      bcd        <= 4'd0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      active     <= active_n;
      pending    <= pending_n;
      pend       <= pend_n;
      an         <= an_n;
      bcd        <= bcd_n;
      blank      <= blank_n;
      frame_done <= boundary;
      load_ready <= ~pend_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl. Instance a uses NDIG=4, PRESCALE=4,
//   DEAD=1, LZB=1. Instance b uses NDIG=4, PRESCALE=1, DEAD=0 to cover
//   back-to-back digits.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, valid_a, ready_a, blank_a, fd_a;
  logic [15:0] data_a;
  logic [3:0]  bcd_a, an_a;
  logic        en_b, valid_b, ready_b, blank_b, fd_b;
  logic [15:0] data_b;
  logic [3:0]  bcd_b, an_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NDIG(4), .PRESCALE(4), .DEAD(1), .LZB(1)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .load_valid(valid_a),
    .load_data(data_a), .load_ready(ready_a), .bcd(bcd_a), .an(an_a),
    .blank(blank_a), .frame_done(fd_a)
  );

  seg_scan_ctrl #(.NDIG(4), .PRESCALE(1), .DEAD(0), .LZB(1)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .load_valid(valid_b),
    .load_data(data_b), .load_ready(ready_b), .bcd(bcd_b), .an(an_b),
    .blank(blank_b), .frame_done(fd_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of instance a, checked against the expected picture.
  // pos is the cycle position inside the 20-cycle frame:
  // 5 cycles per digit, the last of those 5 being the dead gap.
  task automatic step_chk(input logic [15:0] frame, input int pos,
                          input logic fd_exp);
    int         d, sub;
    logic [3:0] v, an_e, bcd_e;
    logic       bl_e;
    tick();
    d   = pos / 5;
    sub = pos % 5;
    v   = frame[d*4 +: 4];
    if (sub == 4) begin
      an_e = 4'd0; bcd_e = 4'd0; bl_e = 1'b1;
    end else begin
      an_e = 4'd1 << d;
      if (v > 4'd9 || (d != 0 && (frame >> (d*4)) == 16'd0)) begin
        bl_e = 1'b1; bcd_e = 4'd0;
      end else begin
        bl_e = 1'b0; bcd_e = v;
      end
    end
    check_eq($sformatf("an pos%0d", pos),    32'(an_a),    32'(an_e));
    check_eq($sformatf("bcd pos%0d", pos),   32'(bcd_a),   32'(bcd_e));
    check_eq($sformatf("blank pos%0d", pos), 32'(blank_a), 32'(bl_e));
    check_eq($sformatf("fd pos%0d", pos),    32'(fd_a),    32'(fd_exp));
  endtask

  initial begin
    logic [15:0] frame;

    // Clock/reset block
    rst = 1'b1; en_a = 1'b0; valid_a = 1'b0; data_a = '0;
    en_b = 1'b0; valid_b = 1'b0; data_b = '0;
    tick(); tick();
    check_eq("rst an",    32'(an_a),    32'h0);
    check_eq("rst bcd",   32'(bcd_a),   32'h0);
    check_eq("rst blank", 32'(blank_a), 32'h1);
    check_eq("rst fd",    32'(fd_a),    32'h0);
    check_eq("rst ready", 32'(ready_a), 32'h1);
    rst = 1'b0;

    // Load 4321 while off: transfer, then commit the next cycle.
    valid_a = 1'b1; data_a = 16'h4321;
    tick();
    check_eq("off load ready lo", 32'(ready_a), 32'h0);
    valid_a = 1'b0; data_a = '0;
    tick();
    check_eq("off load ready hi", 32'(ready_a), 32'h1);

    // Scan order, tear-free load, then leading zero / invalid digit.
    en_a = 1'b1;
    for (int t = 0; t < 100; t++) begin
      frame = (t < 60) ? 16'h4321 : (t < 80) ? 16'h9876 : 16'h00A0;
      step_chk(frame, t % 20, (t % 20 == 0) && (t > 0));
      if (t == 45) begin
        valid_a = 1'b1; data_a = 16'h9876;
      end
      if (t == 46) begin
        valid_a = 1'b0; data_a = 16'h0;
      end
      if (t >= 46 && t <= 59) check_eq($sformatf("ready held t%0d", t), 32'(ready_a), 32'h0);
      if (t == 62) begin
        check_eq("ready after commit", 32'(ready_a), 32'h1);
        valid_a = 1'b1; data_a = 16'h00A0;
      end
      if (t == 63) begin
        valid_a = 1'b0; data_a = 16'h0;
        check_eq("ready after 2nd load", 32'(ready_a), 32'h0);
      end
    end

    // Drop enable mid-frame: display off next cycle, no frame pulse.
    for (int p = 0; p < 8; p++) step_chk(16'h00A0, p, p == 0);
    en_a = 1'b0;
    tick();
    check_eq("off an",    32'(an_a),    32'h0);
    check_eq("off blank", 32'(blank_a), 32'h1);
    check_eq("off bcd",   32'(bcd_a),   32'h0);
    for (int i = 0; i < 25; i++) begin
      tick();
      check_eq($sformatf("off fd %0d", i), 32'(fd_a), 32'h0);
      check_eq($sformatf("off an %0d", i), 32'(an_a), 32'h0);
    end

    // Load 5555 while off, then re-enable: first digit is idx0 showing 5.
    valid_a = 1'b1; data_a = 16'h5555;
    tick();
    check_eq("5555 ready lo", 32'(ready_a), 32'h0);
    valid_a = 1'b0; data_a = '0;
    tick();
    check_eq("5555 ready hi", 32'(ready_a), 32'h1);
    en_a = 1'b1;
    for (int p = 0; p < 12; p++) step_chk(16'h5555, p, 1'b0);

    // Reset mid-scan at idx2 with a frame pending; reset must clear it all.
    valid_a = 1'b1; data_a = 16'h1111;
    step_chk(16'h5555, 12, 1'b0);
    valid_a = 1'b0; data_a = '0;
    check_eq("pending before rst", 32'(ready_a), 32'h0);
    rst = 1'b1;
    tick();
    check_eq("midrst an",    32'(an_a),    32'h0);
    check_eq("midrst blank", 32'(blank_a), 32'h1);
    check_eq("midrst ready", 32'(ready_a), 32'h1);
    check_eq("midrst fd",    32'(fd_a),    32'h0);
    tick();
    rst = 1'b0;
    // Active frame is all zeros now: idx0 shows 0, the others are blanked.
    for (int p = 0; p < 10; p++) step_chk(16'h0000, p, 1'b0);

    // No dead time, one cycle per digit.
    valid_b = 1'b1; data_b = 16'h4321;
    tick();
    valid_b = 1'b0; data_b = '0;
    tick();
    check_eq("b ready", 32'(ready_b), 32'h1);
    en_b = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick();
      check_eq($sformatf("b an t%0d", t),  32'(an_b),  32'(4'd1 << (t % 4)));
      check_eq($sformatf("b bcd t%0d", t), 32'(bcd_b), 32'((t % 4) + 1));
      check_eq($sformatf("b fd t%0d", t),  32'(fd_b),  32'((t % 4 == 0) && (t > 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
